stream_frame_source: RTL and testbench

// - Avalon-ST video source: packs camera-side pixel strobes into sop/valid/eop

---
 rtl/stream_frame_source_if.sv | 27 ++
 rtl/stream_frame_source.sv | 196 +++++++++++++++++++
 tb/tb_stream_frame_source.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_frame_source_if.sv
// Avalon-ST video stream bundle between the frame source (master) and the
// first downstream filter (slave). readyLatency is 0.
interface stream_frame_source_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] data_out;
  logic              sop_out;
  logic              eop_out;
  logic              valid_out;
  logic              ready_in;

  modport master (
    output data_out,
    output sop_out,
    output eop_out,
    output valid_out,
    input  ready_in
  );

  modport slave (
    input  data_out,
    input  sop_out,
    input  eop_out,
    input  valid_out,
    output ready_in
  );
endinterface

// File: rtl/stream_frame_source.sv
// Capture-to-Avalon-ST frame packetiser with an elastic show-ahead FIFO.
// Optional macro TEST_PATTERN_EN adds pattern_en, which replaces pixels by {x[7:4],y[7:4],4'hF}.
module stream_frame_source #(
  parameter int DATA_W     = 12,
  parameter int FRAME_W    = 320,
  parameter int FRAME_H    = 240,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [DATA_W-1:0]     pix_in,
  input  logic                  pix_valid,
`ifdef TEST_PATTERN_EN
  input  logic                  pattern_en,
`endif
  stream_frame_source_if.master st,
  output logic                  overflow,
  output logic                  frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;
  // Counters keep at least 8 bits so the test pattern can always take bits [7:4].
  localparam int XW = ($clog2(FRAME_W) < 8) ? 8 : $clog2(FRAME_W);
  localparam int YW = ($clog2(FRAME_H) < 8) ? 8 : $clog2(FRAME_H);
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ABORT  = 2'd2
  } state_t;

  function automatic logic [EW-1:0] make_entry(input logic sop, input logic eop,
                                               input logic [DATA_W-1:0] data);
    make_entry = {sop, eop, data};
  endfunction

  state_t              state_r, state_s;
  logic [XW-1:0]       x_r, x_s, cur_x_s;
  logic [YW-1:0]       y_r, y_s, cur_y_s;
  logic                pushed_r, pushed_s;
  logic                overflow_r, overflow_s;
  logic                frame_done_r;
  logic [EW-1:0]       mem_r [FIFO_DEPTH];
  logic [AW:0]         wr_ptr_r, rd_ptr_r;
  logic                full_s, empty_s, push_s, pop_s, take_s;
  logic                first_s, last_s;
  logic [EW-1:0]       entry_s, head_s;
  logic [DATA_W-1:0]   pix_data_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head_s  = mem_r[rd_ptr_r[AW-1:0]];
  assign pop_s   = !empty_s && st.ready_in;

  // A frame_start pixel taken in IDLE is pixel 0 of the new frame.
  assign cur_x_s = (state_r == ST_IDLE) ? {XW{1'b0}} : x_r;
  assign cur_y_s = (state_r == ST_IDLE) ? {YW{1'b0}} : y_r;
  assign first_s = (cur_x_s == {XW{1'b0}}) && (cur_y_s == {YW{1'b0}});
  assign last_s  = (cur_x_s == X_LAST) && (cur_y_s == Y_LAST);

`ifdef TEST_PATTERN_EN
  assign pix_data_s = pattern_en ? DATA_W'({cur_x_s[7:4], cur_y_s[7:4], 4'hF}) : pix_in;
`else
  assign pix_data_s = pix_in;
`endif

  // Framing FSM: decides what (if anything) is pushed this cycle.
  always_comb begin
    state_s    = state_r;
    x_s        = x_r;
    y_s        = y_r;
    pushed_s   = pushed_r;
    overflow_s = overflow_r;
    push_s     = 1'b0;
    take_s     = 1'b0;
    entry_s    = {EW{1'b0}};

    case (state_r)
      ST_IDLE: begin
        if (frame_start) begin
          state_s  = ST_ACTIVE;
          x_s      = {XW{1'b0}};
          y_s      = {YW{1'b0}};
          pushed_s = 1'b0;
          take_s   = pix_valid;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (frame_start) begin
          state_s = ST_ABORT;
        end else begin
          take_s  = pix_valid;
        end
      end
      ST_ABORT: begin
        if (!pushed_r) begin
          state_s = ST_IDLE;
        end else if (!full_s) begin
          push_s  = 1'b1;
          entry_s = make_entry(1'b0, 1'b1, {DATA_W{1'b0}});
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ABORT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (take_s) begin
      if (full_s) begin
        overflow_s = 1'b1;
        state_s    = ST_ABORT;
      end else begin
        push_s   = 1'b1;
        pushed_s = 1'b1;
        entry_s  = make_entry(first_s, last_s, pix_data_s);
        if (last_s) begin
          state_s = ST_IDLE;
          x_s     = {XW{1'b0}};
          y_s     = {YW{1'b0}};
        end else if (cur_x_s == X_LAST) begin
          x_s     = {XW{1'b0}};
          y_s     = cur_y_s + Y_ONE;
        end else begin
          x_s     = cur_x_s + X_ONE;
          y_s     = cur_y_s;
        end
      end
    end else begin
      take_s = 1'b0;
    end
  end

  // State, counters, pointers and sticky/pulse flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      x_r          <= {XW{1'b0}};
      y_r          <= {YW{1'b0}};
      pushed_r     <= 1'b0;
      overflow_r   <= 1'b0;
      frame_done_r <= 1'b0;
      wr_ptr_r     <= {(AW+1){1'b0}};
      rd_ptr_r     <= {(AW+1){1'b0}};
    end else begin
      state_r      <= state_s;
      x_r          <= x_s;
      y_r          <= y_s;
      pushed_r     <= pushed_s;
      overflow_r   <= overflow_s;
      frame_done_r <= pop_s && head_s[EW-2];
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // FIFO storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= entry_s;
    end
  end

  // Head entry is gated so every stream output reads 0 while empty or in reset.
  always_comb begin
    st.valid_out = !empty_s;
    if (!empty_s) begin
      st.sop_out  = head_s[EW-1];
      st.eop_out  = head_s[EW-2];
      st.data_out = head_s[DATA_W-1:0];
    end else begin
      st.sop_out  = 1'b0;
      st.eop_out  = 1'b0;
      st.data_out = {DATA_W{1'b0}};
    end
  end

  assign overflow   = overflow_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_stream_frame_source.sv
// Scoreboard bench for stream_frame_source: stimulus pushes expected beats,
// a negedge monitor pops and compares every transferred beat.
`timescale 1ns/1ps
module tb_stream_frame_source;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          pix_valid;
  logic          ready;
  logic [DW-1:0] pix;
  logic          ovf_a, ovf_b, fd_a, fd_b;

  always #5 clk = ~clk;

  stream_frame_source_if #(.DATA_W(DW)) st_a ();
  stream_frame_source_if #(.DATA_W(DW)) st_b ();
  assign st_a.ready_in = ready;
  assign st_b.ready_in = ready;

  // Short frame (N=8) for framing, back-pressure, abort and reset tests.
  stream_frame_source #(.DATA_W(DW), .FRAME_W(4), .FRAME_H(2), .FIFO_DEPTH(16)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pix_in      (pix),
    .pix_valid   (pix_valid),
`ifdef TEST_PATTERN_EN
    .pattern_en  (1'b0),
`endif
    .st          (st_a),
    .overflow    (ovf_a),
    .frame_done  (fd_a)
  );

  // Longer frame (N=32) so 17 pixels can overflow the 16-entry FIFO mid-frame.
  stream_frame_source #(.DATA_W(DW), .FRAME_W(4), .FRAME_H(8), .FIFO_DEPTH(16)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pix_in      (pix),
    .pix_valid   (pix_valid),
`ifdef TEST_PATTERN_EN
    .pattern_en  (1'b0),
`endif
    .st          (st_b),
    .overflow    (ovf_b),
    .frame_done  (fd_b)
  );

`ifdef TEST_PATTERN_EN
  logic ovf_c, fd_c;
  stream_frame_source_if #(.DATA_W(DW)) st_c ();
  assign st_c.ready_in = ready;
  stream_frame_source #(.DATA_W(DW), .FRAME_W(32), .FRAME_H(2), .FIFO_DEPTH(16)) dut_c (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pix_in      (pix),
    .pix_valid   (pix_valid),
    .pattern_en  (1'b1),
    .st          (st_c),
    .overflow    (ovf_c),
    .frame_done  (fd_c)
  );
`endif

  int            sel = 0;
  logic          m_valid, m_sop, m_eop, m_fd, m_ovf;
  logic [DW-1:0] m_data;

  always_comb begin
    m_valid = st_a.valid_out;
    m_sop   = st_a.sop_out;
    m_eop   = st_a.eop_out;
    m_data  = st_a.data_out;
    m_fd    = fd_a;
    m_ovf   = ovf_a;
    if (sel == 1) begin
      m_valid = st_b.valid_out;
      m_sop   = st_b.sop_out;
      m_eop   = st_b.eop_out;
      m_data  = st_b.data_out;
      m_fd    = fd_b;
      m_ovf   = ovf_b;
    end
`ifdef TEST_PATTERN_EN
    if (sel == 2) begin
      m_valid = st_c.valid_out;
      m_sop   = st_c.sop_out;
      m_eop   = st_c.eop_out;
      m_data  = st_c.data_out;
      m_fd    = fd_c;
      m_ovf   = ovf_c;
    end
`endif
  end

  typedef struct {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
    int            due;
  } beat_t;

  beat_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  int    fd_cnt      = 0;
  bit    chk_stable  = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: hold-stability while stalled, and beat-by-beat scoreboard compare.
  initial begin
    logic          hold_v;
    logic          hold_sop, hold_eop;
    logic [DW-1:0] hold_data;
    beat_t         b;
    hold_v = 1'b0;
    hold_sop = 1'b0;
    hold_eop = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (m_fd === 1'b1) fd_cnt = fd_cnt + 1;
        if (chk_stable && hold_v) begin
          vectors = vectors + 1;
          if (m_valid !== 1'b1 || m_sop !== hold_sop || m_eop !== hold_eop || m_data !== hold_data) begin
            miscompares = miscompares + 1;
            $display("FAIL hold_stable: got v=%0b sop=%0b eop=%0b data=%h, required v=1 sop=%0b eop=%0b data=%h",
                     m_valid, m_sop, m_eop, m_data, hold_sop, hold_eop, hold_data);
          end
        end
        hold_v    = m_valid && !ready;
        hold_sop  = m_sop;
        hold_eop  = m_eop;
        hold_data = m_data;
        if (m_valid === 1'b1 && ready === 1'b1) begin
          vectors = vectors + 1;
          if (exp_q.size() == 0) begin
            miscompares = miscompares + 1;
            $display("FAIL unexpected_beat: got sop=%0b eop=%0b data=%h, required no beat", m_sop, m_eop, m_data);
          end else begin
            b = exp_q.pop_front();
            if (m_sop !== b.sop || m_eop !== b.eop || m_data !== b.data || (b.due >= 0 && cyc != b.due)) begin
              miscompares = miscompares + 1;
              $display("FAIL beat: got sop=%0b eop=%0b data=%h cyc=%0d, required sop=%0b eop=%0b data=%h cyc=%0d",
                       m_sop, m_eop, m_data, cyc, b.sop, b.eop, b.data, b.due);
            end
          end
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fs, input logic pv, input logic [DW-1:0] d);
    frame_start = fs;
    pix_valid   = pv;
    pix         = d;
  endtask

  task automatic expect_beat(input logic s, input logic e, input logic [DW-1:0] d, input int due);
    beat_t b;
    b.sop  = s;
    b.eop  = e;
    b.data = d;
    b.due  = due;
    exp_q.push_back(b);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors = vectors + 1;
    if (act !== req) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n = n + 1;
    end
    repeat (3) tick();
    vectors = vectors + 1;
    if (exp_q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    ready = 1'b0;
    drive(1'b0, 1'b0, 12'h000);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",    32'(m_valid), 32'd0);
    check("rst_data",     32'(m_data),  32'd0);
    check("rst_overflow", 32'(m_ovf),   32'd0);
    check("rst_done",     32'(m_fd),    32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // T1: framing and 1-cycle latency
    ready  = 1'b1;
    fd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, 1'b1, DW'(i + 1));
      expect_beat(i == 0, i == 7, DW'(i + 1), cyc + 1);
      tick();
    end
    drive(1'b0, 1'b0, 12'h000);
    drain("t1");
    check("t1_frame_done", 32'(fd_cnt), 32'd1);

    // T2: 6-cycle stall mid-frame
    fd_cnt     = 0;
    chk_stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ready = !(i >= 3 && i < 9);
      if (i < 8) begin
        drive(i == 0, 1'b1, DW'(12'h020 + i));
        expect_beat(i == 0, i == 7, DW'(12'h020 + i), -1);
      end else begin
        drive(1'b0, 1'b0, 12'h000);
      end
      tick();
    end
    ready = 1'b1;
    drive(1'b0, 1'b0, 12'h000);
    drain("t2");
    chk_stable = 1'b0;
    check("t2_frame_done", 32'(fd_cnt), 32'd1);

    // T4: early frame_start after 3 pixels
    fd_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 1'b1, DW'(12'h041 + i));
      expect_beat(i == 0, 1'b0, DW'(12'h041 + i), cyc + 1);
      tick();
    end
    drive(1'b1, 1'b1, 12'h044);
    expect_beat(1'b0, 1'b1, 12'h000, -1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, DW'(12'h050 + i));
      tick();
    end
    drive(1'b0, 1'b0, 12'h000);
    drain("t4");
    check("t4_overflow",   32'(m_ovf),  32'd0);
    check("t4_frame_done", 32'(fd_cnt), 32'd1);

    // T5: asynchronous reset with a packet open
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 1'b1, DW'(12'h061 + i));
      tick();
    end
    drive(1'b0, 1'b0, 12'h000);
    tick();
    check("t5_valid_before", 32'(m_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_valid", 32'(m_valid), 32'd0);
    check("t5_rst_sop",   32'(m_sop),   32'd0);
    check("t5_rst_data",  32'(m_data),  32'd0);
    check("t5_rst_done",  32'(m_fd),    32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    ready  = 1'b1;
    fd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, 1'b1, DW'(12'h071 + i));
      expect_beat(i == 0, i == 7, DW'(12'h071 + i), cyc + 1);
      tick();
    end
    drive(1'b0, 1'b0, 12'h000);
    drain("t5");
    check("t5_frame_done", 32'(fd_cnt), 32'd1);

    // T3: overflow on the 17th pixel of a 32-pixel frame
    sel   = 1;
    ready = 1'b0;
    pulse_reset();
    fd_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      drive(i == 0, 1'b1, DW'(12'h100 + i));
      if (i < 16) expect_beat(i == 0, 1'b0, DW'(12'h100 + i), -1);
      tick();
    end
    drive(1'b0, 1'b0, 12'h000);
    expect_beat(1'b0, 1'b1, 12'h000, -1);
    tick();
    check("t3_overflow_set", 32'(m_ovf), 32'd1);
    ready = 1'b1;
    drain("t3");
    check("t3_frame_done", 32'(fd_cnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, DW'(12'h200 + i));
      tick();
    end
    drive(1'b0, 1'b0, 12'h000);
    tick();
    check("t3_idle_after", 32'(m_valid), 32'd0);
    check("t3_overflow_sticky", 32'(m_ovf), 32'd1);

`ifdef TEST_PATTERN_EN
    // T6: generated pattern, 32x2 frame
    sel = 2;
    pulse_reset();
    ready  = 1'b1;
    fd_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      logic [7:0]    px, py;
      logic [DW-1:0] d;
      px = 8'(i % 32);
      py = 8'(i / 32);
      d  = (i == 17) ? 12'h10F : {px[7:4], py[7:4], 4'hF};
      drive(i == 0, 1'b1, 12'hABC);
      expect_beat(i == 0, i == 63, d, cyc + 1);
      tick();
    end
    drive(1'b0, 1'b0, 12'h000);
    drain("t6");
    check("t6_frame_done", 32'(fd_cnt), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
